// File: rtl/spi_fifo_bridge_pkg.sv
// Shared SPI definitions: burst FSM encoding and word-counter constants
// used across the SPI host-side blocks.
package spi_defs;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_END = 2'd3
    } burst_state_e;

    localparam int unsigned WORD_CNT_W = 16;
    localparam logic [WORD_CNT_W-1:0] WORD_CNT_MAX = '1;

    function automatic logic [WORD_CNT_W-1:0] word_cnt_inc(input logic [WORD_CNT_W-1:0] cnt);
        return (cnt == WORD_CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/level; a write while full
// is refused even if a read happens in the same cycle.
module spi_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  push, pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_fifo_bridge.sv
// Host-side bridge between TX/RX FIFOs and an SPI master: launches bursts,
// chains queued words on the master's CHECK_NEXT cycle and captures replies.
module spi_fifo_bridge import spi_defs::*; #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_wr_en,
    input  logic [DATA_WIDTH-1:0] tx_wr_data,
    output logic                  tx_full,
    output logic [LW-1:0]         tx_level,
    input  logic                  rx_rd_en,
    output logic [DATA_WIDTH-1:0] rx_rd_data,
    output logic                  rx_empty,
    output logic [LW-1:0]         rx_level,
    input  logic                  go,
    input  logic                  stop,
    input  logic                  err_clr,
    output logic                  tx_ovf,
    output logic                  rx_ovf,
    output logic                  burst_busy,
    output logic                  burst_done,
    output logic [15:0]           word_cnt,
    output logic                  m_start,
    output logic                  m_txe,
    output logic [DATA_WIDTH-1:0] m_tx_data,
    input  logic                  m_done,
    input  logic [DATA_WIDTH-1:0] m_rx_data,
    input  logic                  m_busy
);

    burst_state_e          state_q, state_d;
    logic                  stop_pending_q, stop_pending_d;
    logic                  done_d_q;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic                  tx_pop, tx_empty;
    logic                  rx_push, rx_full;

    assign m_txe      = tx_empty || stop_pending_q || (state_q != ST_RUN);
    assign burst_busy = (state_q != ST_IDLE);
    assign word_cnt   = word_cnt_q;
    assign tx_ovf     = tx_ovf_q;
    assign rx_ovf     = rx_ovf_q;

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        word_cnt_d     = word_cnt_q;
        tx_pop         = 1'b0;
        rx_push        = 1'b0;
        m_start        = 1'b0;
        burst_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_pending_d = 1'b0;
                if (go && !tx_empty) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                m_start    = 1'b1;
                tx_pop     = 1'b1;
                word_cnt_d = '0;
                state_d    = ST_RUN;
                if (stop) stop_pending_d = 1'b1;
            end
            ST_RUN: begin
                if (stop) stop_pending_d = 1'b1;
                // done_d marks the master's CHECK_NEXT cycle: capture reply, feed next word
                if (done_d_q) begin
                    rx_push    = 1'b1;
                    word_cnt_d = word_cnt_inc(word_cnt_q);
                    if (!m_txe) tx_pop  = 1'b1;
                    else        state_d = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (!m_busy) begin
                    burst_done     = 1'b1;
                    stop_pending_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new error event in the same cycle as err_clr keeps the flag set
        tx_ovf_d = (tx_wr_en && tx_full) ? 1'b1 : (err_clr ? 1'b0 : tx_ovf_q);
        rx_ovf_d = (rx_push && rx_full)  ? 1'b1 : (err_clr ? 1'b0 : rx_ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            stop_pending_q <= 1'b0;
            done_d_q       <= 1'b0;
            word_cnt_q     <= '0;
            tx_ovf_q       <= 1'b0;
            rx_ovf_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            done_d_q       <= m_done;
            word_cnt_q     <= word_cnt_d;
            tx_ovf_q       <= tx_ovf_d;
            rx_ovf_q       <= rx_ovf_d;
        end
    end

    spi_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (tx_wr_en),
        .wr_data(tx_wr_data),
        .rd_en  (tx_pop),
        .rd_data(m_tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    spi_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (rx_push),
        .wr_data(m_rx_data),
        .rd_en  (rx_rd_en),
        .rd_data(rx_rd_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Scoreboard bench for spi_fifo_bridge: a behavioural SPI master drives the
// master-side ports, a queue-based model predicts every observable response.
module tb_spi_fifo_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk, rst_n;
    logic          tx_wr_en, rx_rd_en, go, stop, err_clr;
    logic [DW-1:0] tx_wr_data, rx_rd_data, m_tx_data, m_rx_data;
    logic          tx_full, rx_empty, tx_ovf, rx_ovf, burst_busy, burst_done;
    logic [LW-1:0] tx_level, rx_level;
    logic [15:0]   word_cnt;
    logic          m_start, m_txe, m_done, m_busy;

    spi_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
        .go(go), .stop(stop), .err_clr(err_clr), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
        .burst_busy(burst_busy), .burst_done(burst_done), .word_cnt(word_cnt),
        .m_start(m_start), .m_txe(m_txe), .m_tx_data(m_tx_data),
        .m_done(m_done), .m_rx_data(m_rx_data), .m_busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave reply the behavioural master returns for each word it shifts out
    function automatic logic [31:0] resp(input logic [31:0] w);
        return {w[15:0], w[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- behavioural SPI master ----------------
    initial begin : master
        int            mst;
        int            cnt;
        logic [31:0]   word;
        logic          s_start, s_txe, s_rst;
        logic [31:0]   s_data;
        m_busy = 1'b0; m_done = 1'b0; m_rx_data = '0;
        mst = 0; cnt = 0; word = '0;
        forever begin
            @(negedge clk);
            s_start = m_start; s_txe = m_txe; s_data = m_tx_data; s_rst = rst_n;
            @(posedge clk); #1;
            if (!s_rst) begin
                mst = 0; m_busy = 1'b0; m_done = 1'b0;
            end else begin
                case (mst)
                    0: if (s_start) begin
                        word = s_data; m_busy = 1'b1; cnt = $urandom_range(4, 2); mst = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin m_done = 1'b1; m_rx_data = resp(word); mst = 2; end
                    end
                    2: begin m_done = 1'b0; mst = 3; end
                    default: begin
                        if (!s_txe) begin word = s_data; cnt = $urandom_range(4, 2); mst = 1; end
                        else begin m_busy = 1'b0; mst = 0; end
                    end
                endcase
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_rx_q[$];
    bit          exp_tx_ovf, exp_rx_ovf, active, stop_seen, go_pend, prev_done;
    int          words;
    logic [31:0] cur_word;
    int          start_cnt = 0, done_cnt = 0, check_cnt = 0;

    initial begin : monitor
        int          pre_tx, pre_rx;
        bit          pop_tx, rx_new_v, exp_txe, tx_ev, rx_ev;
        logic [31:0] rx_new;
        exp_tx_ovf = 0; exp_rx_ovf = 0; active = 0; stop_seen = 0; go_pend = 0;
        prev_done = 0; words = 0; cur_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_tx_q.delete(); exp_rx_q.delete();
                exp_tx_ovf = 0; exp_rx_ovf = 0; active = 0; stop_seen = 0;
                go_pend = 0; prev_done = 0; words = 0;
            end else begin
                pre_tx = exp_tx_q.size(); pre_rx = exp_rx_q.size();
                pop_tx = 0; rx_new_v = 0; rx_ev = 0; rx_new = '0;
                chk("burst_busy", burst_busy, active);
                if (m_start || go_pend) chk("m_start", m_start, go_pend);
                go_pend = 0;
                if (m_start && pre_tx > 0) begin
                    start_cnt++; words = 0;
                    chk("tx_word_launch", m_tx_data, exp_tx_q[0]);
                    cur_word = exp_tx_q[0]; pop_tx = 1;
                end
                if (prev_done) begin
                    check_cnt++;
                    exp_txe = (pre_tx == 0) || stop_seen;
                    chk("m_txe", m_txe, exp_txe);
                    if (words < 65535) words++;
                    if (pre_rx < DEPTH) begin rx_new_v = 1; rx_new = resp(cur_word); end
                    else rx_ev = 1;
                    if (!exp_txe) begin
                        chk("tx_word_chain", m_tx_data, exp_tx_q[0]);
                        cur_word = exp_tx_q[0]; pop_tx = 1;
                    end
                end
                prev_done = m_done;
                if (burst_done) begin
                    done_cnt++;
                    chk("burst_done_in_burst", active, 1);
                    chk("word_cnt", word_cnt, words);
                end
                if (stop && active) stop_seen = 1;
                if (go && !active && pre_tx > 0) begin active = 1; go_pend = 1; end
                if (burst_done) begin active = 0; stop_seen = 0; end
                if (pop_tx) exp_tx_q.delete(0);
                tx_ev = tx_wr_en && (pre_tx >= DEPTH);
                if (tx_wr_en && pre_tx < DEPTH) exp_tx_q.push_back(tx_wr_data);
                if (rx_rd_en && pre_rx > 0) begin
                    chk("rx_rd_data", rx_rd_data, exp_rx_q[0]);
                    exp_rx_q.delete(0);
                end
                if (rx_new_v) exp_rx_q.push_back(rx_new);
                if (tx_ev) exp_tx_ovf = 1; else if (err_clr) exp_tx_ovf = 0;
                if (rx_ev) exp_rx_ovf = 1; else if (err_clr) exp_rx_ovf = 0;
            end
        end
    end

    // ---------------- host-side stimulus tasks ----------------
    task automatic push(input logic [31:0] w);
        @(posedge clk); #1; tx_wr_en = 1'b1; tx_wr_data = w;
        @(posedge clk); #1; tx_wr_en = 1'b0;
    endtask

    task automatic do_go();
        @(posedge clk); #1; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic do_errclr();
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
    endtask

    task automatic do_pop();
        @(posedge clk); #1; rx_rd_en = 1'b1;
        @(posedge clk); #1; rx_rd_en = 1'b0;
    endtask

    task automatic read_all();
        int n;
        n = exp_rx_q.size();
        for (int i = 0; i < n; i++) do_pop();
    endtask

    task automatic wait_burst(input string name);
        int old;
        old = done_cnt;
        for (int i = 0; i < 500 && done_cnt == old; i++) @(posedge clk);
        chk({name, "_burst_done_seen"}, done_cnt > old, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_check(input string name);
        int old;
        old = check_cnt;
        for (int i = 0; i < 200 && check_cnt == old; i++) @(posedge clk);
        chk({name, "_check_seen"}, check_cnt > old, 1);
    endtask

    task automatic wait_start(input string name);
        int old;
        old = start_cnt;
        for (int i = 0; i < 50 && start_cnt == old; i++) @(posedge clk);
        chk({name, "_start_seen"}, start_cnt > old, 1);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk); #2;
        chk({tag, "_tx_level"}, tx_level, exp_tx_q.size());
        chk({tag, "_tx_full"}, tx_full, exp_tx_q.size() == DEPTH);
        chk({tag, "_rx_level"}, rx_level, exp_rx_q.size());
        chk({tag, "_rx_empty"}, rx_empty, exp_rx_q.size() == 0);
        chk({tag, "_tx_ovf"}, tx_ovf, exp_tx_ovf);
        chk({tag, "_rx_ovf"}, rx_ovf, exp_rx_ovf);
        chk({tag, "_burst_busy"}, burst_busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_level"}, tx_level, 0);
        chk({tag, "_rx_level"}, rx_level, 0);
        chk({tag, "_tx_full"}, tx_full, 0);
        chk({tag, "_rx_empty"}, rx_empty, 1);
        chk({tag, "_m_start"}, m_start, 0);
        chk({tag, "_burst_busy"}, burst_busy, 0);
        chk({tag, "_burst_done"}, burst_done, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
        chk({tag, "_tx_ovf"}, tx_ovf, 0);
        chk({tag, "_rx_ovf"}, rx_ovf, 0);
        chk({tag, "_m_txe"}, m_txe, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin : stimulus
        int s;
        rst_n = 1'b0; tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
        go = 1'b0; stop = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check_reset_values("reset");
        @(posedge clk); #1; rst_n = 1'b1;
        check_quiet("post_reset");

        // Two-word burst, replies land in order
        s = start_cnt;
        push(32'hA5A5_A5A5);
        push(32'h1234_5678);
        do_go();
        wait_burst("two_word");
        chk("two_word_starts", start_cnt, s + 1);
        chk("two_word_cnt", word_cnt, 2);
        check_quiet("two_word");
        chk("two_word_rx_head", rx_rd_data, resp(32'hA5A5_A5A5));
        read_all();
        check_quiet("two_word_drained");

        // TX overflow with no burst, then clear; error event beats same-cycle clear
        for (int i = 0; i < DEPTH + 1; i++) push(32'hC000_0000 + i);
        check_quiet("tx_over");
        chk("tx_over_full", tx_full, 1);
        chk("tx_over_flag", tx_ovf, 1);
        do_errclr();
        check_quiet("tx_over_clr");
        @(posedge clk); #1; tx_wr_en = 1'b1; tx_wr_data = 32'hDEAD_BEEF; err_clr = 1'b1;
        @(posedge clk); #1; tx_wr_en = 1'b0; err_clr = 1'b0;
        check_quiet("tx_ovf_wins");
        chk("tx_ovf_wins_flag", tx_ovf, 1);
        do_errclr();

        // Drain full TX into RX (RX becomes full), then a one-word burst overflows RX
        do_go();
        wait_burst("fill_rx");
        chk("fill_rx_cnt", word_cnt, DEPTH);
        check_quiet("fill_rx");
        push(32'h0BAD_F00D);
        do_go();
        wait_burst("rx_over");
        check_quiet("rx_over");
        chk("rx_over_flag", rx_ovf, 1);
        chk("rx_over_level", rx_level, DEPTH);
        read_all();
        do_errclr();
        check_quiet("rx_over_clr");

        // Stop after the first CHECK_NEXT: exactly two words move
        for (int i = 0; i < 4; i++) push(32'h5000_0000 + i);
        do_go();
        wait_check("stop");
        do_stop();
        wait_burst("stop");
        chk("stop_word_cnt", word_cnt, 2);
        check_quiet("stop");
        chk("stop_tx_level", tx_level, 2);
        read_all();
        do_go();
        wait_burst("stop_rest");
        read_all();
        check_quiet("stop_rest");

        // go with TX empty is ignored; reset in RUN clears everything
        s = start_cnt;
        do_go();
        repeat (10) @(posedge clk);
        chk("empty_go_no_start", start_cnt, s);
        chk("empty_go_busy", burst_busy, 0);
        for (int i = 0; i < 3; i++) push($urandom);
        do_go();
        wait_check("reset_mid");
        #1; rst_n = 1'b0;
        @(negedge clk); #2;
        check_reset_values("reset_mid");
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (12) @(posedge clk);
        chk("reset_mid_starts", start_cnt, s + 1);
        check_quiet("after_reset_mid");

        // Word pushed mid-burst is chained into the running burst
        s = start_cnt;
        push(32'h7777_0001);
        do_go();
        wait_start("chain");
        push(32'h7777_0002);
        wait_burst("chain");
        chk("chain_word_cnt", word_cnt, 2);
        chk("chain_starts", start_cnt, s + 1);
        read_all();
        check_quiet("chain");

        // Randomised bursts with extra host pushes while busy
        for (int it = 0; it < 8; it++) begin
            int n, extra;
            n = $urandom_range(5, 1);
            extra = $urandom_range(2, 0);
            for (int k = 0; k < n; k++) push($urandom);
            do_go();
            for (int k = 0; k < extra; k++) push($urandom);
            wait_burst("rand");
            check_quiet("rand");
            read_all();
            if ($urandom_range(1, 0) == 1) do_errclr();
            check_quiet("rand_drained");
        end

        for (int k = 0; k < 3 && exp_tx_q.size() > 0; k++) begin
            do_go();
            wait_burst("final_drain");
            read_all();
        end
        check_quiet("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_fifo_bridge.md
SPI_FIFO_BRIDGE -- requirements
Module: spi_fifo_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width; SHALL match the SPI master MAX_DATA_WIDTH.
REQ-002 Parameter DEPTH, default 8: entries per FIFO; SHALL be a power of two, at least 2.
REQ-003 Ports SHALL be (LW = $clog2(DEPTH)+1):
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 tx_wr_en  in  1  host push to TX FIFO
 tx_wr_data  in  DATA_WIDTH  host TX word
 tx_full  out  1  TX FIFO full
 tx_level  out  LW  TX occupancy
 rx_rd_en  in  1  host pop from RX FIFO
 rx_rd_data  out  DATA_WIDTH  RX FIFO head (show-ahead)
 rx_empty  out  1  RX FIFO empty
 rx_level  out  LW  RX occupancy
 go  in  1  start burst (pulse)
 stop  in  1  end burst after current word (pulse)
 err_clr  in  1  clear sticky error flags
 tx_ovf  out  1  sticky: push while TX full
 rx_ovf  out  1  sticky: RX word dropped, RX full
 burst_busy  out  1  burst in progress
 burst_done  out  1  one-cycle pulse at burst end
 word_cnt  out  16  words completed in current/last burst
 m_start  out  1  to master start
 m_txe  out  1  to master txe (1 = no next word)
 m_tx_data  out  DATA_WIDTH  to master tx_data
 m_done  in  1  from master done
 m_rx_data  in  DATA_WIDTH  from master rx_data
 m_busy  in  1  from master busy

Function
REQ-004 TX FIFO push SHALL occur when tx_wr_en && !tx_full; tx_wr_en && tx_full SHALL drop the word and set tx_ovf, even if a pop occurs that cycle.
REQ-005 m_tx_data SHALL be the TX FIFO head combinationally; m_txe SHALL be tx_empty || stop_pending || state != RUN.
REQ-006 FSM states IDLE, LAUNCH, RUN, WAIT_END.
REQ-007 IDLE: go with TX non-empty -> LAUNCH; go with TX empty SHALL be ignored; go while not IDLE SHALL be ignored.
REQ-008 LAUNCH (one cycle): m_start=1, TX pop, word_cnt cleared to 0, -> RUN.
REQ-009 done_d SHALL be m_done delayed one clk; word loading and RX capture occur on done_d (the master's CHECK_NEXT cycle).
REQ-010 RUN: on done_d, RX push of m_rx_data (or drop + rx_ovf if RX full, RX pop that cycle not counted as freeing space) and word_cnt+1 saturating at 65535; if !m_txe that cycle, TX pop.
REQ-011 stop in LAUNCH/RUN SHALL set stop_pending, forcing m_txe=1; cleared on return to IDLE.
REQ-012 RUN -> WAIT_END on done_d with m_txe=1; WAIT_END -> IDLE on first cycle m_busy=0, with burst_done=1 that cycle.
REQ-013 burst_busy SHALL be 1 in LAUNCH, RUN, WAIT_END.
REQ-014 RX pop SHALL occur when rx_rd_en && !rx_empty; rx_rd_en while empty SHALL be ignored, no flag.
REQ-015 Simultaneous push and pop on one FIFO SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-016 err_clr SHALL clear tx_ovf/rx_ovf; a same-cycle error event SHALL win (flag stays 1).
REQ-017 Host pushes during a burst SHALL be accepted; a word present at the done_d cycle SHALL be chained into the burst.

Reset
REQ-018 rst_n low SHALL asynchronously set state=IDLE, both FIFOs empty (tx_level=rx_level=0, tx_full=0, rx_empty=1), m_start=0, burst_busy=0, burst_done=0, word_cnt=0, tx_ovf=rx_ovf=0, stop_pending=0, done_d=0; m_txe=1.
REQ-019 Reset mid-burst SHALL discard FIFO contents; no m_start until a new go.

Structure
REQ-020 FSM state encoding SHALL live in shared package/header spi_defs alongside SPI-wide constants.
REQ-021 FIFOs SHALL be two instances of sub-module spi_sync_fifo (DATA_WIDTH, DEPTH, show-ahead, full/empty/level).

Verification
REQ-022 Push 0xA5A5A5A5, 0x12345678; go -> one m_start, m_txe=0 at first done_d, 1 at second; burst_done after m_busy falls; word_cnt=2; RX holds two words in order.
REQ-023 Push DEPTH+1 words with no burst -> tx_full=1, tx_level=DEPTH, tx_ovf=1; err_clr -> tx_ovf=0.
REQ-024 Fill RX (DEPTH words, host never reads), run 1-word burst -> rx_ovf=1, rx_level stays DEPTH.
REQ-025 Start 4-word burst, stop after first done_d -> exactly 2 words transferred, tx_level=2, word_cnt=2.
REQ-026 go with TX empty -> no m_start, burst_busy=0; assert rst_n low during RUN -> all outputs at REQ-018 values next cycle.
REQ-027 Push 1 word, go, push second word before first m_done -> chained, word_cnt=2, single m_start.
